// File: rtl/fifo_rd_stream.sv
// Read-side adapter for an async FIFO: issues reads on credit and hides the FIFO read latency behind a small skid buffer.
// Optional macro FIFO_RD_STREAM_CNT_EN adds the word_cnt transfer counter and the sticky ovf_err flag.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  fifo_rd_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [31:0]           word_cnt,
  output logic                  ovf_err
`endif
);

  localparam int BUF_DEPTH = RD_LATENCY + 1;
  localparam int OW = $clog2(BUF_DEPTH + 1);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = OW + 2;

  logic [RD_LATENCY-1:0] r_issue;
  logic [DATA_WIDTH-1:0] r_buf [BUF_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [OW-1:0]         r_occ;
  logic [CW-1:0]         w_inflight;
  logic [CW-1:0]         w_credit;
  logic                  w_capture;
  logic                  w_pop;
  logic                  w_rd_en;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      w_inflight = w_inflight + CW'(r_issue[i]);
    end
  end

  // Stream handshake: a word moves when m_valid && m_ready on a rising edge;
  // m_valid never drops and m_data never changes while the word is unaccepted.
  assign w_pop     = m_valid && m_ready;
  assign w_capture = r_issue[RD_LATENCY-1];
  // Credit counts buffered plus in-flight words, freeing the slot popped this cycle.
  assign w_credit  = CW'(r_occ) + w_inflight - (w_pop ? CW'(1) : CW'(0));
  assign w_rd_en   = !rd_rst && !fifo_rd_empty && (w_credit < CW'(BUF_DEPTH));

  assign fifo_rd_en = w_rd_en;
  assign m_valid    = (r_occ != '0);
  assign m_data     = r_buf[r_rd_ptr];
  assign busy       = m_valid || (w_inflight != '0);

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_issue  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_issue[0] <= w_rd_en;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_issue[i] <= r_issue[i-1];
      end
      if (w_capture) begin
        r_buf[r_wr_ptr] <= fifo_rd_data;
        r_wr_ptr        <= f_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_inc(r_rd_ptr);
      end
      case ({w_capture, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge rd_clk) begin
    if (!rd_rst) begin
      assert (!(w_capture && (r_occ == OW'(BUF_DEPTH))));
    end
  end

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [31:0] r_word_cnt;
  logic        r_ovf_err;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_word_cnt <= '0;
      r_ovf_err  <= 1'b0;
    end else begin
      if (w_pop) begin
        r_word_cnt <= r_word_cnt + 32'd1;
      end
      if (w_capture && (r_occ == OW'(BUF_DEPTH))) begin
        r_ovf_err <= 1'b1;
      end
    end
  end

  assign word_cnt = r_word_cnt;
  assign ovf_err  = r_ovf_err;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: one instance at RD_LATENCY=1 and one at RD_LATENCY=2,
// each fed by a small behavioural FIFO with matching read latency.
module tb_fifo_rd_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mism     = 0;

  // ---------------- instance 1: RD_LATENCY = 1 ----------------
  logic       empty1, rd_en1, mv1, busy1;
  logic       rdy1 = 1'b0;
  logic [7:0] din1, md1;
  logic [7:0] mem1 [0:511];
  int         push1 = 0;
  int         pop1  = 0;
  logic [7:0] dp1;

  // ---------------- instance 2: RD_LATENCY = 2 ----------------
  logic       empty2, rd_en2, mv2, busy2;
  logic       rdy2 = 1'b0;
  logic [7:0] din2, md2;
  logic [7:0] mem2 [0:511];
  int         push2 = 0;
  int         pop2  = 0;
  logic [7:0] dp2a, dp2b;

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [31:0] wc1, wc2;
  logic        ovf1, ovf2;
`endif

  fifo_rd_stream #(.DATA_WIDTH(8), .RD_LATENCY(1)) u_dut1 (
    .rd_clk        (clk),
    .rd_rst        (rst),
    .fifo_rd_empty (empty1),
    .fifo_rd_data  (din1),
    .fifo_rd_en    (rd_en1),
    .m_valid       (mv1),
    .m_data        (md1),
    .m_ready       (rdy1),
    .busy          (busy1)
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    .word_cnt      (wc1),
    .ovf_err       (ovf1)
`endif
  );

  fifo_rd_stream #(.DATA_WIDTH(8), .RD_LATENCY(2)) u_dut2 (
    .rd_clk        (clk),
    .rd_rst        (rst),
    .fifo_rd_empty (empty2),
    .fifo_rd_data  (din2),
    .fifo_rd_en    (rd_en2),
    .m_valid       (mv2),
    .m_data        (md2),
    .m_ready       (rdy2),
    .busy          (busy2)
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    .word_cnt      (wc2),
    .ovf_err       (ovf2)
`endif
  );

  // Behavioural FIFOs: a read accepted at an edge shows up RD_LATENCY edges later.
  assign empty1 = (push1 == pop1);
  assign din1   = dp1;
  always @(posedge clk) begin
    if (rst) begin
      dp1 <= '0;
    end else if (rd_en1) begin
      dp1  <= mem1[pop1];
      pop1 <= pop1 + 1;
    end
  end

  assign empty2 = (push2 == pop2);
  assign din2   = dp2b;
  always @(posedge clk) begin
    if (rst) begin
      dp2a <= '0;
      dp2b <= '0;
    end else begin
      dp2b <= dp2a;
      if (rd_en2) begin
        dp2a <= mem2[pop2];
        pop2 <= pop2 + 1;
      end
    end
  end

  // Monitors sample on the falling edge, between input updates.
  logic [7:0] rcv1 [0:511];
  int         rcv_cyc1 [0:511];
  int         n1 = 0;
  int         ren_cnt1 = 0;
  int         ren_empty1 = 0;

  always @(negedge clk) begin
    if (rd_en1) ren_cnt1 <= ren_cnt1 + 1;
    if (rd_en1 && empty1) ren_empty1 <= ren_empty1 + 1;
    if (mv1 && rdy1) begin
      rcv1[n1]     <= md1;
      rcv_cyc1[n1] <= cyc;
      n1           <= n1 + 1;
    end
  end

  logic [7:0] rcv2 [0:511];
  int         n2 = 0;
  int         ren_cnt2 = 0;
  int         ren_empty2 = 0;
  int         max_out2 = 0;
  int         unstable2 = 0;
  logic       prev_stall2 = 1'b0;
  logic [7:0] prev_d2 = '0;

  always @(negedge clk) begin
    if (rd_en2) ren_cnt2 <= ren_cnt2 + 1;
    if (rd_en2 && empty2) ren_empty2 <= ren_empty2 + 1;
    if (ren_cnt2 - n2 > max_out2) max_out2 <= ren_cnt2 - n2;
    if (prev_stall2 && (!mv2 || md2 !== prev_d2)) unstable2 <= unstable2 + 1;
    prev_stall2 <= mv2 && !rdy2;
    prev_d2     <= md2;
    if (mv2 && rdy2) begin
      rcv2[n2] <= md2;
      n2       <= n2 + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mism++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int base_en, base_n, base_bad, k;
    logic [3:0] pat;
    pat = 4'b1001;

    // Reset with FIFO 1 pre-filled with 0x00..0x0F, consumer ready.
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) mem1[i] = 8'(i);
    push1 = 16;
    rdy1  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_rd_en1", {31'd0, rd_en1}, 32'd0);
      chk("rst_m_valid1", {31'd0, mv1}, 32'd0);
      chk("rst_busy1", {31'd0, busy1}, 32'd0);
      chk("rst_m_data1", {24'd0, md1}, 32'd0);
    end
    chk("rst_m_valid2", {31'd0, mv2}, 32'd0);
    chk("rst_m_data2", {24'd0, md2}, 32'd0);

    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rel_rd_en1", {31'd0, rd_en1}, 32'd1);
    chk("rel_m_valid1_c0", {31'd0, mv1}, 32'd0);
    @(negedge clk);
    chk("rel_m_valid1_c1", {31'd0, mv1}, 32'd0);
    chk("rel_busy1_c1", {31'd0, busy1}, 32'd1);
    @(negedge clk);
    chk("first_m_valid1", {31'd0, mv1}, 32'd1);
    chk("first_m_data1", {24'd0, md1}, 32'h00);

    // Streaming at one word per clock.
    repeat (15) @(negedge clk);
    chk("last_m_valid1", {31'd0, mv1}, 32'd1);
    chk("last_m_data1", {24'd0, md1}, 32'h0F);
    chk("last_busy1", {31'd0, busy1}, 32'd1);
    @(negedge clk);
    chk("after_busy1", {31'd0, busy1}, 32'd0);
    chk("after_m_valid1", {31'd0, mv1}, 32'd0);
    chk("burst_count1", n1, 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("burst_data1[%0d]", i), {24'd0, rcv1[i]}, 32'(i));
      chk($sformatf("burst_gap1[%0d]", i), rcv_cyc1[i] - rcv_cyc1[0], 32'(i));
    end

    // Isolated single words separated by an empty FIFO.
    base_en  = ren_cnt1;
    base_n   = n1;
    base_bad = ren_empty1;
    @(posedge clk); #1;
    mem1[push1] = 8'hA5;
    push1++;
    repeat (6) @(posedge clk);
    #1;
    mem1[push1] = 8'h5A;
    push1++;
    repeat (8) @(posedge clk);
    #1;
    chk("sparse_rd_en_pulses", ren_cnt1 - base_en, 32'd2);
    chk("sparse_transfers", n1 - base_n, 32'd2);
    chk("sparse_word0", {24'd0, rcv1[base_n]}, 32'hA5);
    chk("sparse_word1", {24'd0, rcv1[base_n+1]}, 32'h5A);
    chk("sparse_rd_while_empty", ren_empty1 - base_bad, 32'd0);

    // RD_LATENCY=2 with ready pattern 1,0,0,1.
    for (int i = 0; i < 10; i++) mem2[i] = 8'(8'h20 + i);
    push2 = 10;
    k = 0;
    while (n2 < 10 && k < 80) begin
      rdy2 = pat[k % 4];
      @(posedge clk); #1;
      k++;
    end
    rdy2 = 1'b0;
    chk("bp_count2", n2, 32'd10);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_data2[%0d]", i), {24'd0, rcv2[i]}, 32'(8'h20 + i));
    end
    chk("bp_outstanding_le3", {31'd0, (max_out2 <= 3)}, 32'd1);
    chk("bp_stable2", unstable2, 32'd0);
    chk("bp_rd_while_empty2", ren_empty2, 32'd0);

    // Reset with two words buffered and one in flight.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) mem2[push2 + i] = 8'(8'h40 + i);
    push2 = push2 + 3;
    repeat (4) @(posedge clk);
    #3;
    chk("pre_rst_m_valid2", {31'd0, mv2}, 32'd1);
    chk("pre_rst_m_data2", {24'd0, md2}, 32'h40);
    chk("pre_rst_busy2", {31'd0, busy2}, 32'd1);
    chk("pre_rst_rd_en2", {31'd0, rd_en2}, 32'd0);
    rst = 1'b1;
    #1;
    chk("async_rst_m_valid2", {31'd0, mv2}, 32'd0);
    chk("async_rst_busy2", {31'd0, busy2}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    rdy2 = 1'b1;
    base_n = n2;
    repeat (10) @(posedge clk);
    #1;
    chk("no_stale_transfers2", n2 - base_n, 32'd0);
    chk("no_stale_m_valid2", {31'd0, mv2}, 32'd0);
    chk("no_stale_busy2", {31'd0, busy2}, 32'd0);

`ifdef FIFO_RD_STREAM_CNT_EN
    chk("cnt_after_rst1", wc1, 32'd0);
    chk("cnt_after_rst2", wc2, 32'd0);
    base_n = n1;
    for (int i = 0; i < 300; i++) mem1[push1 + i] = 8'(i);
    push1 = push1 + 300;
    k = 0;
    while (n1 - base_n < 300 && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("cnt_transfers1", n1 - base_n, 32'd300);
    chk("word_cnt1", wc1, 32'h12C);
    chk("ovf_err1", {31'd0, ovf1}, 32'd0);
    chk("ovf_err2", {31'd0, ovf2}, 32'd0);
`endif

    chk("total_rd_while_empty1", ren_empty1, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
